bus_interval_timer: RTL and testbench
=====================================

Name: bus_interval_timer

Overview:
- Memory-mapped millisecond interval timer on the shared 8-bit processor bus (BUS_ADDR/BUS_DATA/BUS_WE).
- Sits directly upstream of the Processor interrupt input: drives BUS_INTERRUPTS_RAISE[1] and consumes BUS_INTERRUPTS_ACK[1].
- Generates a periodic interrupt every PERIOD ticks, holds it until acknowledged, and flags missed interrupts.

Parameters:
- BASE_ADDR, 8'hF0, first of 4 consecutive register addresses (BASE_ADDR[1:0] must be 0).
- CLKS_PER_TICK, 50000, CLK cycles per timer tick (1 ms at 50 MHz); must be ≥2.
- PERIOD_RST, 8'd100, reset value of the PERIOD register.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-low reset: sampled on the CLK rising edge, 0 = reset.
- BUS_ADDR  in  8  bus address.
- BUS_DATA  inout  8  bus data; driven only during own read, otherwise high-Z.
- BUS_WE  in  1  1 = write cycle, 0 = read.
- IRQ_RAISE  out  1  interrupt request to Processor line 1.
- IRQ_ACK  in  1  single-cycle acknowledge from Processor.

Behaviour:
- Register map (offset from BASE_ADDR):
  - +0 COUNT: R = free-running tick counter (8-bit, wraps 255->0). W (any data) = clear COUNT, interval counter and prescaler.
  - +1 PERIOD: R/W, reset PERIOD_RST.
  - +2 CTRL: R/W. bit0 TIMER_EN (reset 1), bit1 IRQ_EN (reset 1). Bits 7:2 read 0.
  - +3 STATUS: R. bit0 = IRQ_RAISE, bit1 = MISSED (sticky). W (any data) = clear MISSED. Bits 7:2 read 0.
- Writes take effect at the CLK edge where BUS_WE=1 and the address matches.
- Reads:
  - Address match with BUS_WE=0 registers read data and an output-enable.
  - BUS_DATA is driven on the following cycle (1-cycle latency), for exactly one cycle per matching cycle.
  - BUS_DATA is high-Z otherwise.
- Prescaler:
  - Counts 0..CLKS_PER_TICK-1 while TIMER_EN=1; emits a 1-cycle tick on the terminal count.
  - Frozen (value held) while TIMER_EN=0.
- On each tick:
  - COUNT increments.
  - The interval counter increments.
  - If interval+1 == PERIOD: interval <= 0 and an event fires.
- PERIOD=0: no events; the interval counter holds at 0.
- Writing PERIOD resets the interval counter to 0. The prescaler is not reset.
- Event firing:
  - Event with IRQ_EN=1 and IRQ_RAISE=0: IRQ_RAISE <= 1 next edge.
  - Event with IRQ_EN=1 and IRQ_RAISE=1, no ack this cycle: MISSED <= 1; IRQ_RAISE stays 1.
  - Event with IRQ_EN=0: no raise, no MISSED.
- IRQ_ACK=1 with no event in the same cycle: IRQ_RAISE <= 0.
- IRQ_ACK=1 and event in the same cycle (IRQ_EN=1): IRQ_RAISE stays 1 (new request); MISSED unchanged.
- Clearing IRQ_EN while IRQ_RAISE=1 does not drop the request; only IRQ_ACK or reset drops it.
- Reset (also mid-operation):
  - IRQ_RAISE=0, BUS_DATA high-Z (OE=0), COUNT=0, interval=0, prescaler=0, MISSED=0.
  - PERIOD=PERIOD_RST, CTRL=8'b11.

Decomposition:
- Shared bus package holds:
  - Register offset constants TMR_COUNT=0, TMR_PERIOD=1, TMR_CTRL=2, TMR_STATUS=3.
  - CTRL/STATUS bit-index constants.
  - Default BASE_ADDR for the timer (8'hF0), alongside the other peripheral base constants.
- One sub-module is natural: tick_prescaler (parameter CLKS_PER_TICK; inputs CLK, RESET, EN, CLR; output TICK).
- Bus decode, registers and IRQ logic stay in the top module.

Test Plan:
- Reset with RESET=0 for 2 edges, CLKS_PER_TICK=10 -> IRQ_RAISE=0 and BUS_DATA=Z. Reading +1 returns 100 on the cycle after the address; reading +2 returns 8'h03.
- Write PERIOD=3, never ack -> IRQ_RAISE rises 30 clocks after the write. The next event 30 clocks later sets MISSED: STATUS read = 8'h03.
- PERIOD=3; ack with a 1-cycle IRQ_ACK 5 clocks after each raise -> raises are exactly 30 clocks apart, MISSED stays 0, COUNT advances by 3 per raise.
- IRQ_ACK asserted in the exact cycle an event fires -> IRQ_RAISE remains 1 with no low gap, and STATUS bit1 = 0.
- Write CTRL=8'h00, wait 100 clocks -> COUNT unchanged and no raise. Write CTRL=8'h03 -> counting resumes from the held prescaler value.
- Write PERIOD=0 -> no raise over 500 clocks. Then assert RESET mid-count -> all reset values restored, and PERIOD reads 100.

Source files
------------

// File: rtl/bus_interval_timer_pkg.sv
// Shared processor-bus constants: peripheral base addresses plus the
// interval timer's register offsets and CTRL/STATUS bit positions.
package bus_interval_timer_pkg;

  localparam logic [7:0] SWITCH_BASE_ADDR = 8'h80;
  localparam logic [7:0] LED_BASE_ADDR    = 8'hC0;
  localparam logic [7:0] TIMER_BASE_ADDR  = 8'hF0;

  localparam logic [1:0] TMR_COUNT  = 2'd0;
  localparam logic [1:0] TMR_PERIOD = 2'd1;
  localparam logic [1:0] TMR_CTRL   = 2'd2;
  localparam logic [1:0] TMR_STATUS = 2'd3;

  localparam int CTRL_TIMER_EN_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT   = 1;
  localparam int STATUS_IRQ_BIT    = 0;
  localparam int STATUS_MISSED_BIT = 1;

endpackage

// File: rtl/bus_interval_timer_tick_prescaler.sv
// Divides CLK down to a one-cycle TICK every CLKS_PER_TICK enabled cycles.
// EN=0 freezes the count in place; CLR restarts it at zero.
module tick_prescaler #(
  parameter int CLKS_PER_TICK = 50000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (CLR) begin
      cnt_d = '0;
    end else if (EN) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign TICK = EN && !CLR && (cnt_q == LAST);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_interval_timer.sv
// Memory-mapped millisecond interval timer: COUNT/PERIOD/CTRL/STATUS registers
// on the 8-bit processor bus and a level interrupt held until acknowledged.
module bus_interval_timer
  import bus_interval_timer_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR     = TIMER_BASE_ADDR,
  parameter int         CLKS_PER_TICK = 50000,
  parameter logic [7:0] PERIOD_RST    = 8'd100
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  output logic       IRQ_RAISE,
  input  logic       IRQ_ACK
);

  logic [7:0] count_q, count_d;
  logic [7:0] interval_q, interval_d;
  logic [7:0] period_q, period_d;
  logic       timer_en_q, timer_en_d;
  logic       irq_en_q, irq_en_d;
  logic       irq_q, irq_d;
  logic       missed_q, missed_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_oe_q, rd_oe_d;

  logic       addr_hit;
  logic [1:0] reg_off;
  logic       wr_count, wr_period, wr_ctrl, wr_status;
  logic       tick;
  logic       fire;

  always_comb begin
    addr_hit  = (BUS_ADDR[7:2] == BASE_ADDR[7:2]);
    reg_off   = BUS_ADDR[1:0];
    wr_count  = addr_hit && BUS_WE && (reg_off == TMR_COUNT);
    wr_period = addr_hit && BUS_WE && (reg_off == TMR_PERIOD);
    wr_ctrl   = addr_hit && BUS_WE && (reg_off == TMR_CTRL);
    wr_status = addr_hit && BUS_WE && (reg_off == TMR_STATUS);
  end

  tick_prescaler #(
    .CLKS_PER_TICK (CLKS_PER_TICK)
  ) u_prescaler (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (timer_en_q),
    .CLR   (wr_count),
    .TICK  (tick)
  );

  // A COUNT write clears everything; a PERIOD write restarts the interval but
  // still lets COUNT advance on a coincident tick.
  always_comb begin
    count_d    = count_q;
    interval_d = interval_q;
    fire       = 1'b0;
    if (wr_count) begin
      count_d    = '0;
      interval_d = '0;
    end else if (tick) begin
      count_d = count_q + 8'd1;
      if (wr_period || (period_q == 8'd0)) begin
        interval_d = '0;
      end else if ((interval_q + 8'd1) == period_q) begin
        interval_d = '0;
        fire       = 1'b1;
      end else begin
        interval_d = interval_q + 8'd1;
      end
    end else if (wr_period) begin
      interval_d = '0;
    end
  end

  always_comb begin
    period_d   = wr_period ? BUS_DATA : period_q;
    timer_en_d = wr_ctrl ? BUS_DATA[CTRL_TIMER_EN_BIT] : timer_en_q;
    irq_en_d   = wr_ctrl ? BUS_DATA[CTRL_IRQ_EN_BIT] : irq_en_q;
  end

  // Raise/ack handshake: IRQ_RAISE is a level held until a one-cycle IRQ_ACK.
  // An event landing on the ack cycle re-arms the request instead of missing.
  always_comb begin
    irq_d    = irq_q;
    missed_d = wr_status ? 1'b0 : missed_q;
    if (fire && irq_en_q) begin
      if (irq_q && !IRQ_ACK) begin
        missed_d = 1'b1;
      end
      irq_d = 1'b1;
    end else if (IRQ_ACK) begin
      irq_d = 1'b0;
    end
  end

  always_comb begin
    rd_oe_d   = addr_hit && !BUS_WE;
    rd_data_d = '0;
    unique case (reg_off)
      TMR_COUNT:  rd_data_d = count_q;
      TMR_PERIOD: rd_data_d = period_q;
      TMR_CTRL: begin
        rd_data_d[CTRL_TIMER_EN_BIT] = timer_en_q;
        rd_data_d[CTRL_IRQ_EN_BIT]   = irq_en_q;
      end
      TMR_STATUS: begin
        rd_data_d[STATUS_IRQ_BIT]    = irq_q;
        rd_data_d[STATUS_MISSED_BIT] = missed_q;
      end
      default: rd_data_d = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      count_q    <= '0;
      interval_q <= '0;
      period_q   <= PERIOD_RST;
      timer_en_q <= 1'b1;
      irq_en_q   <= 1'b1;
      irq_q      <= 1'b0;
      missed_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_oe_q    <= 1'b0;
    end else begin
      count_q    <= count_d;
      interval_q <= interval_d;
      period_q   <= period_d;
      timer_en_q <= timer_en_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      missed_q   <= missed_d;
      rd_data_q  <= rd_data_d;
      rd_oe_q    <= rd_oe_d;
    end
  end

  assign IRQ_RAISE = irq_q;
  assign BUS_DATA  = rd_oe_q ? rd_data_q : 8'hzz;

endmodule

// File: tb/tb_bus_interval_timer.sv
// Bench for bus_interval_timer with a 10-clock tick; bus reads feed an expected
// queue, and an undriven bus is pulled high so a released bus reads 8'hFF.
module tb_bus_interval_timer;

  localparam logic [7:0] A_COUNT  = 8'hF0;
  localparam logic [7:0] A_PERIOD = 8'hF1;
  localparam logic [7:0] A_CTRL   = 8'hF2;
  localparam logic [7:0] A_STATUS = 8'hF3;
  localparam logic [7:0] A_IDLE   = 8'h00;
  localparam logic [7:0] BUS_REL  = 8'hFF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] bus_addr;
  logic       bus_we;
  logic       irq_ack;
  logic       tb_oe;
  logic [7:0] tb_drv;
  tri1  [7:0] bus_data;
  wire        irq_raise;

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  assign bus_data = tb_oe ? tb_drv : 8'hzz;

  bus_interval_timer #(
    .BASE_ADDR     (8'hF0),
    .CLKS_PER_TICK (10),
    .PERIOD_RST    (8'd100)
  ) dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .BUS_ADDR  (bus_addr),
    .BUS_DATA  (bus_data),
    .BUS_WE    (bus_we),
    .IRQ_RAISE (irq_raise),
    .IRQ_ACK   (irq_ack)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // driver tasks: inputs change 1 time unit after each rising edge
  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus_addr = a;
    bus_we   = 1'b1;
    tb_drv   = d;
    tb_oe    = 1'b1;
    tick_n(1);
    bus_we   = 1'b0;
    tb_oe    = 1'b0;
    bus_addr = A_IDLE;
  endtask

  // Address is presented for one cycle; data appears on the following cycle.
  task automatic bus_read(input logic [7:0] a, output logic [7:0] got);
    bus_addr = a;
    bus_we   = 1'b0;
    tick_n(1);
    bus_addr = A_IDLE;
    got      = bus_data;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    tick_n(1);
    irq_ack = 1'b0;
  endtask

  // Quiesce, then arm PERIOD=p with the prescaler freshly cleared.
  // Returns one time unit after the clearing edge.
  task automatic setup_period(input logic [7:0] p);
    bus_write(A_CTRL, 8'h00);
    pulse_ack();
    bus_write(A_STATUS, 8'h00);
    bus_write(A_PERIOD, p);
    bus_write(A_CTRL, 8'h03);
    bus_write(A_COUNT, 8'h00);
  endtask

  task automatic wait_raise(input int limit, output int w);
    w = 0;
    while (w < limit) begin
      tick_n(1);
      w++;
      if (irq_raise) break;
    end
  endtask

  task automatic test_reset();
    logic [7:0] got, exp;
    rst_n = 1'b0;
    tick_n(2);
    rst_n = 1'b1;
    checks++;
    if (irq_raise !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got %b exp 0", irq_raise);
    end
    checks++;
    if (bus_data !== BUS_REL) begin
      errors++;
      $display("FAIL reset_bus_released got %02h exp %02h", bus_data, BUS_REL);
    end
    exp_q.push_back(8'd100);
    bus_read(A_PERIOD, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_period got %02h exp %02h", got, exp);
    end
    exp_q.push_back(8'h03);
    bus_read(A_CTRL, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_ctrl got %02h exp %02h", got, exp);
    end
    tick_n(1);
    checks++;
    if (bus_data !== BUS_REL) begin
      errors++;
      $display("FAIL read_one_cycle got %02h exp %02h", bus_data, BUS_REL);
    end
    exp_q.push_back(8'h00);
    bus_read(A_STATUS, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_status got %02h exp %02h", got, exp);
    end
  endtask

  task automatic test_missed();
    logic [7:0] got, exp;
    int w;
    setup_period(8'd3);
    wait_raise(200, w);
    checks++;
    if (w !== 30) begin
      errors++;
      $display("FAIL missed_first_raise got %0d clocks exp 30", w);
    end
    tick_n(30);
    exp_q.push_back(8'h03);
    bus_read(A_STATUS, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL missed_status got %02h exp %02h", got, exp);
    end
    exp_q.push_back(8'd6);
    bus_read(A_COUNT, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL missed_count got %02h exp %02h", got, exp);
    end
  endtask

  task automatic test_ack();
    logic [7:0] got, exp;
    int w;
    int elapsed;
    setup_period(8'd3);
    elapsed = 0;
    for (int k = 1; k <= 3; k++) begin
      wait_raise(200, w);
      elapsed += w;
      checks++;
      if (elapsed !== 30 * k) begin
        errors++;
        $display("FAIL ack_raise_time k=%0d got %0d exp %0d", k, elapsed, 30 * k);
      end
      tick_n(4);
      pulse_ack();
      exp_q.push_back(8'(3 * k));
      bus_read(A_COUNT, got);
      elapsed += 6;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL ack_count k=%0d got %02h exp %02h", k, got, exp);
      end
    end
    exp_q.push_back(8'h00);
    bus_read(A_STATUS, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL ack_status got %02h exp %02h", got, exp);
    end
  endtask

  task automatic test_ack_on_event();
    logic [7:0] got, exp;
    int w;
    int low_seen;
    setup_period(8'd3);
    wait_raise(200, w);
    checks++;
    if (w !== 30) begin
      errors++;
      $display("FAIL same_cycle_first_raise got %0d exp 30", w);
    end
    // The second event fires on the edge 30 clocks after the first raise.
    low_seen = 0;
    for (int i = 0; i < 29; i++) begin
      tick_n(1);
      if (!irq_raise) low_seen++;
    end
    irq_ack = 1'b1;
    tick_n(1);
    irq_ack = 1'b0;
    if (!irq_raise) low_seen++;
    checks++;
    if (low_seen !== 0) begin
      errors++;
      $display("FAIL same_cycle_no_gap got %0d low cycles exp 0", low_seen);
    end
    exp_q.push_back(8'h01);
    bus_read(A_STATUS, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL same_cycle_status got %02h exp %02h", got, exp);
    end
    pulse_ack();
    checks++;
    if (irq_raise !== 1'b0) begin
      errors++;
      $display("FAIL plain_ack_drop got %b exp 0", irq_raise);
    end
  endtask

  task automatic test_pause();
    logic [7:0] got, exp;
    int w;
    int raised;
    setup_period(8'd3);
    tick_n(14);
    bus_write(A_CTRL, 8'h00);
    exp_q.push_back(8'd1);
    bus_read(A_COUNT, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL pause_count_start got %02h exp %02h", got, exp);
    end
    raised = 0;
    for (int i = 0; i < 100; i++) begin
      tick_n(1);
      if (irq_raise) raised++;
    end
    checks++;
    if (raised !== 0) begin
      errors++;
      $display("FAIL pause_no_raise got %0d raised cycles exp 0", raised);
    end
    exp_q.push_back(8'd1);
    bus_read(A_COUNT, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL pause_count_held got %02h exp %02h", got, exp);
    end
    // Prescaler held at 5 of 0..9, so the next tick is 5 enabled clocks away.
    bus_write(A_CTRL, 8'h03);
    wait_raise(200, w);
    checks++;
    if (w !== 15) begin
      errors++;
      $display("FAIL resume_raise got %0d clocks exp 15", w);
    end
    exp_q.push_back(8'd3);
    bus_read(A_COUNT, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL resume_count got %02h exp %02h", got, exp);
    end
  endtask

  task automatic test_period_zero_and_reset();
    logic [7:0] got, exp;
    int raised;
    setup_period(8'd0);
    raised = 0;
    for (int i = 0; i < 500; i++) begin
      tick_n(1);
      if (irq_raise) raised++;
    end
    checks++;
    if (raised !== 0) begin
      errors++;
      $display("FAIL period0_no_raise got %0d raised cycles exp 0", raised);
    end
    bus_write(A_PERIOD, 8'd1);
    tick_n(40);
    exp_q.push_back(8'h03);
    bus_read(A_STATUS, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL period1_status got %02h exp %02h", got, exp);
    end
    tick_n(3);
    rst_n = 1'b0;
    tick_n(2);
    rst_n = 1'b1;
    checks++;
    if (irq_raise !== 1'b0) begin
      errors++;
      $display("FAIL midreset_irq got %b exp 0", irq_raise);
    end
    checks++;
    if (bus_data !== BUS_REL) begin
      errors++;
      $display("FAIL midreset_bus_released got %02h exp %02h", bus_data, BUS_REL);
    end
    exp_q.push_back(8'd0);
    bus_read(A_COUNT, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL midreset_count got %02h exp %02h", got, exp);
    end
    exp_q.push_back(8'd100);
    bus_read(A_PERIOD, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL midreset_period got %02h exp %02h", got, exp);
    end
    exp_q.push_back(8'h03);
    bus_read(A_CTRL, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL midreset_ctrl got %02h exp %02h", got, exp);
    end
    exp_q.push_back(8'h00);
    bus_read(A_STATUS, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL midreset_status got %02h exp %02h", got, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    bus_addr = A_IDLE;
    bus_we   = 1'b0;
    irq_ack  = 1'b0;
    tb_oe    = 1'b0;
    tb_drv   = 8'h00;
    test_reset();
    test_missed();
    test_ack();
    test_ack_on_event();
    test_pause();
    test_period_zero_and_reset();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
